// File: rtl/u110_pci_target.sv
// U110 PCI target: claims single-DWORD memory cycles in the Amiga window and bridges them to a local REQ/ACK handshake.
// Optional initial-latency retry (target retry with LOCAL_ABORT) is enabled by defining PCI_TGT_RETRY_EN.
module u110_pci_target #(
    parameter logic [31:0] BAR_BASE   = 32'h8000_0000,
    parameter int          BAR_BITS   = 24,
    parameter int          RETRY_CLKS = 16
) (
    input  logic        CLK33,
    input  logic        RESETn,
    input  logic        FRAMEn,
    input  logic        IRDYn,
    input  logic [31:0] AD_IN,
    input  logic [3:0]  CBEn,
    output logic [31:0] AD_OUT,
    output logic        AD_OE,
    output logic        PAR_OUT,
    output logic        PAR_OE,
    output logic        DEVSELn,
    output logic        TRDYn,
    output logic        STOPn,
    output logic        TGT_OE,
    output logic        LOCAL_REQ,
    output logic        LOCAL_RnW,
    output logic [31:0] LOCAL_ADDR,
    output logic [31:0] LOCAL_WDATA,
    output logic [3:0]  LOCAL_BEn,
    input  logic [31:0] LOCAL_RDATA,
    input  logic        LOCAL_ACK,
    output logic        LOCAL_ABORT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY,
        S_CLAIM,
        S_WAIT,
        S_DATA,
        S_STOPW,
        S_TURN
    } state_t;

    state_t      state_q;
    logic        frame_prev_q;
    logic        devsel_q, trdy_q, stop_q, tgt_oe_q;
    logic        ad_oe_q, par_q, par_oe_q;
    logic [31:0] ad_out_q;
    logic        req_q, abort_q, rnw_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  ben_q;

    logic addr_phase_d, cmd_hit_d, bar_hit_d, ack_d, wr_take_d, timeout_d;

    // A new address phase is the first clock of FRAMEn low.
    assign addr_phase_d = !FRAMEn && frame_prev_q;
    assign cmd_hit_d    = (CBEn == 4'b0110) || (CBEn == 4'b0111);
    assign bar_hit_d    = (AD_IN[31:BAR_BITS] == BAR_BASE[31:BAR_BITS]);
    assign ack_d        = (state_q == S_WAIT) && req_q && LOCAL_ACK;
    assign wr_take_d    = (state_q == S_WAIT) && !rnw_q && !req_q && !IRDYn;

`ifdef PCI_TGT_RETRY_EN
    localparam int CNT_W = $clog2(RETRY_CLKS + 1);
    logic [CNT_W-1:0] cnt_q;

    // Counts clocks since DEVSELn fell; the retry fires on the RETRY_CLKS-th edge.
    assign timeout_d = (state_q == S_WAIT) && (cnt_q == CNT_W'(RETRY_CLKS - 1));

    always_ff @(posedge CLK33 or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            cnt_q <= '0;
        end else if (state_q == S_CLAIM || state_q == S_WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_d = 1'b0;
`endif

    always_ff @(posedge CLK33 or negedge RESETn) begin
        // NOTE: the latched address/data registers share the async reset so every output is defined while RESETn is low.
        if (!RESETn) begin
            state_q      <= S_IDLE;
            frame_prev_q <= 1'b1;
            devsel_q     <= 1'b1;
            trdy_q       <= 1'b1;
            stop_q       <= 1'b1;
            tgt_oe_q     <= 1'b0;
            ad_oe_q      <= 1'b0;
            ad_out_q     <= '0;
            par_q        <= 1'b0;
            par_oe_q     <= 1'b0;
            req_q        <= 1'b0;
            abort_q      <= 1'b0;
            rnw_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ben_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge register values.
            frame_prev_q <= FRAMEn;
            par_q        <= ^{ad_out_q, CBEn};
            par_oe_q     <= ad_oe_q;
            abort_q      <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (addr_phase_d) begin
                        addr_q <= AD_IN & 32'hFFFF_FFFC;
                        rnw_q  <= ~CBEn[0];
                        if (cmd_hit_d && bar_hit_d) begin
                            devsel_q <= 1'b0;
                            tgt_oe_q <= 1'b1;
                            state_q  <= S_CLAIM;
                        end else begin
                            state_q <= S_BUSY;
                        end
                    end
                end

                S_BUSY: begin
                    if (FRAMEn && IRDYn) begin
                        state_q <= S_IDLE;
                    end
                end

                S_CLAIM: begin
                    // Read byte enables are valid on C/BE# from the first data clock.
                    if (rnw_q) begin
                        req_q <= 1'b1;
                        ben_q <= CBEn;
                    end
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (ack_d) begin
                        req_q  <= 1'b0;
                        trdy_q <= 1'b0;
                        if (rnw_q) begin
                            ad_out_q <= LOCAL_RDATA;
                            ad_oe_q  <= 1'b1;
                        end
                        if (!FRAMEn) begin
                            stop_q <= 1'b0;
                        end
                        state_q <= S_DATA;
                    end else if (timeout_d) begin
                        req_q   <= 1'b0;
                        abort_q <= 1'b1;
                        stop_q  <= 1'b0;
                        trdy_q  <= 1'b1;
                        state_q <= S_STOPW;
                    end else if (wr_take_d) begin
                        wdata_q <= AD_IN;
                        ben_q   <= CBEn;
                        req_q   <= 1'b1;
                    end
                end

                S_DATA: begin
                    if (!IRDYn) begin
                        ad_oe_q <= 1'b0;
                        trdy_q  <= 1'b1;
                        if (FRAMEn) begin
                            devsel_q <= 1'b1;
                            stop_q   <= 1'b1;
                            state_q  <= S_TURN;
                        end else begin
                            stop_q  <= 1'b0;
                            state_q <= S_STOPW;
                        end
                    end
                end

                S_STOPW: begin
                    trdy_q <= 1'b1;
                    if (FRAMEn) begin
                        devsel_q <= 1'b1;
                        stop_q   <= 1'b1;
                        state_q  <= S_TURN;
                    end else begin
                        stop_q <= 1'b0;
                    end
                end

                S_TURN: begin
                    tgt_oe_q <= 1'b0;
                    state_q  <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign AD_OUT      = ad_out_q;
    assign AD_OE       = ad_oe_q;
    assign PAR_OUT     = par_q;
    assign PAR_OE      = par_oe_q;
    assign DEVSELn     = devsel_q;
    assign TRDYn       = trdy_q;
    assign STOPn       = stop_q;
    assign TGT_OE      = tgt_oe_q;
    assign LOCAL_REQ   = req_q;
    assign LOCAL_RnW   = rnw_q;
    assign LOCAL_ADDR  = addr_q;
    assign LOCAL_WDATA = wdata_q;
    assign LOCAL_BEn   = ben_q;
    assign LOCAL_ABORT = abort_q;

endmodule
